// File: rtl/watchdog_feeder_if.sv
// Signal bundle between the watchdog feeder, the supervised logic and the 4-bit watchdog.
// The slave side is the feeder itself; the master side is whoever drives it.
interface watchdog_feeder_if;
   logic       enable;
   logic       heartbeat;
   logic       timeout;
   logic       wd_enable;
   logic       restart;
   logic       fault;
   logic [1:0] miss_count;

   modport master (
      output enable, heartbeat, timeout,
      input  wd_enable, restart, fault, miss_count
   );

   modport slave (
      input  enable, heartbeat, timeout,
      output wd_enable, restart, fault, miss_count
   );
endinterface

// File: rtl/watchdog_feeder.sv
// Watchdog feeder: kicks the 4-bit watchdog only while the heartbeat proves liveness.
// Define WD_FEEDER_EARLY_FAULT_EN to fault after MAX_MISS consecutive missed windows.
module watchdog_feeder #(
   parameter int KICK_PERIOD = 10,
   parameter int MAX_MISS    = 3
) (
   input logic               clk,
   input logic               rst_n,
   watchdog_feeder_if.slave  bus
);

   localparam int CW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(KICK_PERIOD - 1);

`ifdef WD_FEEDER_EARLY_FAULT_EN
   localparam bit EARLY_FAULT = 1'b1;
`else
   localparam bit EARLY_FAULT = 1'b0;
`endif

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARM     = 3'd1;
   localparam logic [2:0] SERVICE = 3'd2;
   localparam logic [2:0] KICK    = 3'd3;
   localparam logic [2:0] FAULT   = 3'd4;

   logic [2:0]    state, next_state;
   logic [CW-1:0] period_cnt, next_cnt;
   logic          hb_seen, next_hb;
   logic [1:0]    miss_q, next_miss, miss_sat;
   logic          wd_enable_q, restart_q, fault_q;

   assign miss_sat = (miss_q == 2'd3) ? 2'd3 : miss_q + 2'd1;

   // Priority: enable low beats timeout, which beats the window-end kick decision.
   always_comb begin
      next_state = state;
      next_cnt   = period_cnt;
      next_hb    = hb_seen;
      next_miss  = miss_q;
      if (!bus.enable) begin
         next_state = IDLE;
         next_cnt   = '0;
         next_hb    = 1'b0;
         next_miss  = 2'd0;
      end else begin
         case (state)
            IDLE: begin
               next_state = ARM;
            end
            ARM: begin
               if (bus.timeout) begin
                  next_state = FAULT;
               end else begin
                  next_state = SERVICE;
                  next_cnt   = '0;
                  next_hb    = 1'b0;
               end
            end
            SERVICE: begin
               if (bus.timeout) begin
                  next_state = FAULT;
               end else if (period_cnt == LAST) begin
                  if (hb_seen || bus.heartbeat) begin
                     next_state = KICK;
                  end else begin
                     next_miss = miss_sat;
                     next_cnt  = '0;
                     next_hb   = 1'b0;
                     if (EARLY_FAULT && (miss_sat == 2'(MAX_MISS)))
                        next_state = FAULT;
                  end
               end else begin
                  next_cnt = period_cnt + CW'(1);
                  next_hb  = hb_seen | bus.heartbeat;
               end
            end
            KICK: begin
               if (bus.timeout) begin
                  next_state = FAULT;
               end else begin
                  next_state = SERVICE;
                  next_cnt   = '0;
                  next_hb    = bus.heartbeat;
                  next_miss  = 2'd0;
               end
            end
            FAULT: begin
               next_state = FAULT;
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         period_cnt  <= '0;
         hb_seen     <= 1'b0;
         miss_q      <= 2'd0;
         wd_enable_q <= 1'b0;
         restart_q   <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state       <= next_state;
         period_cnt  <= next_cnt;
         hb_seen     <= next_hb;
         miss_q      <= next_miss;
         wd_enable_q <= (next_state != IDLE);
         restart_q   <= (next_state == ARM) || (next_state == KICK);
         fault_q     <= (next_state == FAULT);
      end
   end

   assign bus.wd_enable  = wd_enable_q;
   assign bus.restart    = restart_q;
   assign bus.fault      = fault_q;
   assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_watchdog_feeder.sv
// Directed bench for watchdog_feeder with a behavioural 4-bit watchdog attached.
// Expectations follow WD_FEEDER_EARLY_FAULT_EN (MAX_MISS=1 when it is defined).
module tb_watchdog_feeder;

   localparam int KP = 10;
`ifdef WD_FEEDER_EARLY_FAULT_EN
   localparam int TB_MAX_MISS = 1;
   localparam bit EARLY       = 1'b1;
`else
   localparam int TB_MAX_MISS = 3;
   localparam bit EARLY       = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       force_to = 1'b0;
   logic       mask_to  = 1'b0;
   logic [3:0] wd_cnt;
   logic       wd_to;
   int         n_cmp = 0;
   int         n_err = 0;

   watchdog_feeder_if bus ();

   watchdog_feeder #(
      .KICK_PERIOD (KP),
      .MAX_MISS    (TB_MAX_MISS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference watchdog: cleared when disabled or restarted, saturates at 15.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)              wd_cnt <= 4'd0;
      else if (!bus.wd_enable) wd_cnt <= 4'd0;
      else if (bus.restart)    wd_cnt <= 4'd0;
      else if (wd_cnt != 4'hF) wd_cnt <= wd_cnt + 4'd1;
   end

   assign wd_to       = (wd_cnt == 4'hF);
   assign bus.timeout = (wd_to & ~mask_to) | force_to;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [4:0] obs;
      rst_n = 1'b0;
      bus.enable = 1'b0;
      bus.heartbeat = 1'b0;
      tick;
      tick;
      obs = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count};
      n_cmp++;
      if (obs !== 5'b00000) begin
         n_err++;
         $display("[TB] FAIL reset_hold: got %b want 00000", obs);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick;
         obs = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count};
         n_cmp++;
         if (obs !== 5'b00000) begin
            n_err++;
            $display("[TB] FAIL idle_cycle %0d: got %b want 00000", i, obs);
         end
      end
   endtask

   task automatic test_healthy;
      logic [5:0] obs, exp;
      bus.enable = 1'b1;
      tick;
      obs = {1'b0, bus.wd_enable, bus.restart, bus.fault, bus.miss_count};
      n_cmp++;
      if (obs !== 6'b011000) begin
         n_err++;
         $display("[TB] FAIL arm_pulse: got %b want 011000", obs);
      end
      for (int i = 1; i <= 44; i++) begin
         bus.heartbeat = (i % 11 == 4);
         tick;
         bus.heartbeat = 1'b0;
         obs = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count, bus.timeout};
         exp = {1'b1, (i % 11 == 0), 1'b0, 2'b00, 1'b0};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL healthy cycle %0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   // Heartbeat only in the last window cycle, then once only in the KICK cycle.
   task automatic test_late_heartbeat;
      logic [5:0] obs, exp;
      for (int i = 45; i <= 77; i++) begin
         bus.heartbeat = ((i % 11 == 0) && (i <= 66)) || (i == 67);
         tick;
         bus.heartbeat = 1'b0;
         obs = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count, bus.timeout};
         exp = {1'b1, (i % 11 == 0), 1'b0, 2'b00, 1'b0};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL late_hb cycle %0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_starvation;
      logic [5:0] obs, exp;
      int         fault_at;
      fault_at = EARLY ? 11 : 17;
      for (int j = 1; j <= 30; j++) begin
         tick;
         obs = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count, bus.timeout};
         exp = {1'b1, 1'b0, (j >= fault_at), ((j >= 11) ? 2'd1 : 2'd0), (j >= 16)};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL starve j=%0d: got %b want %b", j, obs, exp);
         end
      end
   endtask

   task automatic test_recovery;
      logic [3:0] obs4;
      logic [4:0] obs5;
      bus.enable = 1'b0;
      tick;
      obs5 = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count};
      n_cmp++;
      if (obs5 !== 5'b00000) begin
         n_err++;
         $display("[TB] FAIL recover_idle: got %b want 00000", obs5);
      end
      bus.enable = 1'b1;
      tick;
      obs4 = {bus.wd_enable, bus.restart, bus.fault, bus.timeout};
      obs5 = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count};
      n_cmp++;
      if ({obs5, obs4[0]} !== 6'b110000) begin
         n_err++;
         $display("[TB] FAIL recover_arm: got %b want 110000", {obs5, obs4[0]});
      end
   endtask

   // Timeout and a window-end heartbeat together must fault and suppress the kick.
   task automatic test_priority;
      logic [2:0] obs;
      for (int i = 1; i <= 10; i++) begin
         tick;
         obs = {bus.wd_enable, bus.restart, bus.fault};
         n_cmp++;
         if (obs !== 3'b100) begin
            n_err++;
            $display("[TB] FAIL prio_window cycle %0d: got %b want 100", i, obs);
         end
      end
      bus.heartbeat = 1'b1;
      force_to = 1'b1;
      tick;
      bus.heartbeat = 1'b0;
      force_to = 1'b0;
      obs = {bus.wd_enable, bus.restart, bus.fault};
      n_cmp++;
      if (obs !== 3'b101) begin
         n_err++;
         $display("[TB] FAIL prio_fault: got %b want 101", obs);
      end
      tick;
      obs = {bus.wd_enable, bus.restart, bus.fault};
      n_cmp++;
      if (obs !== 3'b101) begin
         n_err++;
         $display("[TB] FAIL prio_hold: got %b want 101", obs);
      end
   endtask

   task automatic test_saturation;
      logic [4:0] obs, exp;
      int         m;
      mask_to = 1'b1;
      for (int j = 1; j <= 45; j++) begin
         tick;
         if (EARLY) m = (j >= 11) ? 1 : 0;
         else       m = ((j - 1) / 10 > 3) ? 3 : (j - 1) / 10;
         obs = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count};
         exp = {1'b1, 1'b0, (EARLY && (j >= 11)), 2'(m)};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL saturate j=%0d: got %b want %b", j, obs, exp);
         end
      end
      mask_to = 1'b0;
      bus.enable = 1'b0;
      tick;
   endtask

   task automatic test_async_reset;
      logic [4:0] obs;
      bus.enable = 1'b1;
      tick;
      tick;
      tick;
      n_cmp++;
      if (bus.wd_enable !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL async_pre wd_enable: got %b want 1", bus.wd_enable);
      end
      #2 rst_n = 1'b0;
      #1;
      obs = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count};
      n_cmp++;
      if (obs !== 5'b00000) begin
         n_err++;
         $display("[TB] FAIL async_reset: got %b want 00000", obs);
      end
      bus.enable = 1'b0;
      #2 rst_n = 1'b1;
      tick;
      obs = {bus.wd_enable, bus.restart, bus.fault, bus.miss_count};
      n_cmp++;
      if (obs !== 5'b00000) begin
         n_err++;
         $display("[TB] FAIL post_reset_idle: got %b want 00000", obs);
      end
   endtask

   initial begin
      test_reset;
      test_healthy;
      test_late_heartbeat;
      test_starvation;
      test_recovery;
      test_priority;
      test_recovery;
      test_saturation;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
